// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// lfsr_pkg : shared types and helpers for the LFSR sampler stage.
// Revision : 1.0
// ============================================================================
package lfsr_pkg;

    localparam int LFSR_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEED  = 3'd1,
        WARM  = 3'd2,
        RUN   = 3'd3,
        FAULT = 3'd4
    } sampler_state_t;

    function automatic logic [BYTE_W-1:0] fold32to8(input logic [LFSR_W-1:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_sampler_byte_fifo.sv
`default_nettype none
// ============================================================================
// byte_fifo : small synchronous FIFO with flush; DEPTH must be a power of two >= 2.
// Revision  : 1.0
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so push while full is taken when popping.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_sampler.sv
`default_nettype none
// ============================================================================
// lfsr_sampler : sequences a ring-oscillator LFSR, samples and health-tests it,
//                and streams folded bytes through a valid/ready FIFO.
// Revision     : 1.0
// ============================================================================
module lfsr_sampler
    import lfsr_pkg::*;
#(
    parameter int SAMPLE_DIV  = 16,
    parameter int REP_LIMIT   = 4,
    parameter int SEED_CYCLES = 4,
    parameter int WARMUP      = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              enable,
    input  logic [LFSR_W-1:0] lfsr_o,
    output logic              gen_clear,
    output logic              gen_pre,
    output logic              gen_oe,
    output logic [BYTE_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              fault
);

    localparam int SEED_W = (SEED_CYCLES > 1) ? $clog2(SEED_CYCLES) : 1;
    localparam int WARM_W = (WARMUP > 1)      ? $clog2(WARMUP)      : 1;
    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int REP_W  = $clog2(REP_LIMIT);

    localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(SEED_CYCLES - 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [REP_W-1:0]  REP_TRIP  = REP_W'(REP_LIMIT - 2);

    sampler_state_t    state_q;
    logic [SEED_W-1:0] seed_cnt_q;
    logic [WARM_W-1:0] warm_cnt_q;
    logic [DIV_W-1:0]  div_q;
    logic [REP_W-1:0]  rep_cnt_q;
    logic [REP_W-1:0]  rep_cnt_d;
    logic [LFSR_W-1:0] prev_q;
    logic              first_q;
    logic              gen_clear_q;
    logic              gen_pre_q;
    logic              gen_oe_q;
    logic              fault_q;

    logic [LFSR_W-1:0] sync1_q;
    logic [LFSR_W-1:0] sync2_q;

    logic              capture;
    logic              same_word;
    logic              lockup;
    logic              repeat_hit;
    logic              fault_now;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              fifo_full;
    logic              fifo_empty;

    // Per-bit skew across generator states is tolerated; no bus-level handshake.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= lfsr_o;
            sync2_q <= sync1_q;
        end
    end

    assign capture    = (state_q == RUN) && enable && (div_q == DIV_LAST);
    assign lockup     = (sync2_q == '0);
    assign same_word  = !first_q && (sync2_q == prev_q);
    assign repeat_hit = same_word && (rep_cnt_q == REP_TRIP);
    assign fault_now  = capture && (lockup || repeat_hit);
    assign rep_cnt_d  = same_word ? rep_cnt_q + REP_W'(1) : '0;

    assign fifo_pop   = rnd_valid && rnd_ready;
    assign fifo_push  = capture && !fault_now && (!fifo_full || fifo_pop);
    assign fifo_flush = !enable || (state_q == FAULT) || fault_now;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= IDLE;
            seed_cnt_q  <= '0;
            warm_cnt_q  <= '0;
            div_q       <= '0;
            rep_cnt_q   <= '0;
            prev_q      <= '0;
            first_q     <= 1'b1;
            gen_clear_q <= 1'b1;
            gen_pre_q   <= 1'b0;
            gen_oe_q    <= 1'b1;
            fault_q     <= 1'b0;
        end else if (!enable) begin
            state_q     <= IDLE;
            seed_cnt_q  <= '0;
            warm_cnt_q  <= '0;
            div_q       <= '0;
            rep_cnt_q   <= '0;
            first_q     <= 1'b1;
            gen_clear_q <= 1'b1;
            gen_pre_q   <= 1'b0;
            gen_oe_q    <= 1'b1;
            fault_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q     <= SEED;
                    seed_cnt_q  <= '0;
                    gen_clear_q <= 1'b0;
                    gen_pre_q   <= 1'b1;
                    gen_oe_q    <= 1'b1;
                end
                SEED: begin
                    if (seed_cnt_q == SEED_LAST) begin
                        state_q    <= WARM;
                        warm_cnt_q <= '0;
                        gen_pre_q  <= 1'b0;
                        gen_oe_q   <= 1'b0;
                    end else begin
                        seed_cnt_q <= seed_cnt_q + SEED_W'(1);
                    end
                end
                WARM: begin
                    if (warm_cnt_q == WARM_LAST) begin
                        state_q   <= RUN;
                        div_q     <= '0;
                        rep_cnt_q <= '0;
                        first_q   <= 1'b1;
                    end else begin
                        warm_cnt_q <= warm_cnt_q + WARM_W'(1);
                    end
                end
                RUN: begin
                    div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
                    if (fault_now) begin
                        state_q  <= FAULT;
                        gen_oe_q <= 1'b1;
                        fault_q  <= 1'b1;
                    end else if (capture) begin
                        prev_q    <= sync2_q;
                        first_q   <= 1'b0;
                        rep_cnt_q <= rep_cnt_d;
                    end
                end
                FAULT: begin
                    gen_oe_q <= 1'b1;
                    fault_q  <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    gen_clear_q <= 1'b1;
                    gen_pre_q   <= 1'b0;
                    gen_oe_q    <= 1'b1;
                    fault_q     <= 1'b0;
                end
            endcase
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .clear_n (clear_n),
        .push_i  (fifo_push),
        .din_i   (fold32to8(sync2_q)),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .dout_o  (rnd_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rnd_valid = !fifo_empty;
    assign gen_clear = gen_clear_q;
    assign gen_pre   = gen_pre_q;
    assign gen_oe    = gen_oe_q;
    assign fault     = fault_q;

endmodule
`default_nettype wire
